// File: rtl/data_mem_responder.sv
// Single-outstanding CPU data-memory responder: IDLE accepts, ACCESS reads/writes
// the word array, RESPOND holds the registered result until the CPU takes it.
module data_mem_responder #(
  parameter int MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_size,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);
  localparam int IW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_t;

  state_t      state_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [2:0]  size_q;
  logic [31:0] wdata_q;
  logic        req_ready_q, resp_valid_q, resp_err_q;
  logic [31:0] resp_rdata_q;

  // Contents survive reset; only the declaration initialiser clears them.
  logic [31:0] mem_q [MEM_WORDS] = '{default: '0};

  logic [IW-1:0] idx;
  logic [31:0]   word, shifted, rdata_d, wword_d;
  logic [7:0]    byte_v;
  logic [15:0]   half_v;
  logic [3:0]    be_d;
  logic          err_d;

  always_comb begin
    idx     = addr_q[IW+1:2];
    word    = mem_q[idx];
    shifted = word >> {addr_q[1:0], 3'b000};
    byte_v  = shifted[7:0];
    half_v  = addr_q[1] ? word[31:16] : word[15:0];
    wword_d = wdata_q << {addr_q[1:0], 3'b000};
    err_d   = (addr_q >> 2) >= 32'(MEM_WORDS);
    rdata_d = '0;
    be_d    = '0;
    case (size_q)
      3'b000: begin
        rdata_d = {{24{byte_v[7]}}, byte_v};
        be_d    = 4'b0001 << addr_q[1:0];
      end
      3'b001: begin
        rdata_d = {{16{half_v[15]}}, half_v};
        be_d    = addr_q[1] ? 4'b1100 : 4'b0011;
        if (addr_q[0]) err_d = 1'b1;
      end
      3'b010: begin
        rdata_d = word;
        be_d    = 4'b1111;
        if (addr_q[1:0] != 2'b00) err_d = 1'b1;
      end
      3'b100: begin
        rdata_d = {24'b0, byte_v};
        if (we_q) err_d = 1'b1;
      end
      3'b101: begin
        rdata_d = {16'b0, half_v};
        if (we_q || addr_q[0]) err_d = 1'b1;
      end
      default: err_d = 1'b1;
    endcase
    if (err_d || we_q) rdata_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (req_valid) begin
          we_q        <= req_we;
          addr_q      <= req_addr;
          size_q      <= req_size;
          wdata_q     <= req_wdata;
          req_ready_q <= 1'b0;
          state_q     <= ACCESS;
        end
        ACCESS: begin
          resp_valid_q <= 1'b1;
          resp_rdata_q <= rdata_d;
          resp_err_q   <= err_d;
          state_q      <= RESPOND;
        end
        RESPOND: if (resp_ready) begin
          resp_valid_q <= 1'b0;
          resp_rdata_q <= '0;
          resp_err_q   <= 1'b0;
          req_ready_q  <= 1'b1;
          state_q      <= IDLE;
        end
        default: begin
          req_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  // Reset wins over a store sitting in ACCESS.
  always_ff @(posedge clk) begin
    if (!reset && state_q == ACCESS && we_q && !err_d) begin
      for (int b = 0; b < 4; b++)
        if (be_d[b]) mem_q[idx][8*b +: 8] <= wword_d[8*b +: 8];
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: word/sub-word access, errors,
// back-pressure, throughput and reset during ACCESS.
module tb_data_mem_responder;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0, req_we = 1'b0, resp_ready = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [2:0]  req_size = 3'b010;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;
  int checks = 0, failures = 0, cyc = 0;

  data_mem_responder #(.MEM_WORDS(1024)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Drives one request, waits (bounded) for its response and accepts it.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [2:0] size,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er,
                        output int lat, output int acc);
    int n = 0;
    rd = 'x; er = 1'bx; lat = -1; acc = -1;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size; req_wdata = wd;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    if (!req_ready) begin req_valid = 1'b0; return; end
    @(posedge clk); #1 req_valid = 1'b0; acc = cyc;
    n = 0;
    while (n < 20) begin
      @(negedge clk); n++;
      if (resp_valid) break;
    end
    if (!resp_valid) return;
    lat = n; rd = resp_rdata; er = resp_err;
    resp_ready = 1'b1;
    @(posedge clk); #1 resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got %b exp 0", resp_valid); end
    checks++; if (resp_rdata !== 32'h0) begin failures++; $display("FAIL rst_rdata got %h exp 0", resp_rdata); end
    checks++; if (resp_err !== 1'b0) begin failures++; $display("FAIL rst_err got %b exp 0", resp_err); end
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got %b exp 1", req_ready); end
  endtask

  task automatic test_word();
    logic [31:0] rd; logic er; int lat, acc;
    do_req(1'b1, 32'h10, 3'b010, 32'hDEADBEEF, rd, er, lat, acc);
    checks++; if (er !== 1'b0 || rd !== 32'h0) begin failures++; $display("FAIL sw_resp got err %b rdata %h exp 0/0", er, rd); end
    checks++; if (lat !== 2) begin failures++; $display("FAIL sw_latency got %0d exp 2", lat); end
    do_req(1'b0, 32'h10, 3'b010, 32'h0, rd, er, lat, acc);
    checks++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin failures++; $display("FAIL lw_data got %h err %b exp deadbeef/0", rd, er); end
    checks++; if (lat !== 2) begin failures++; $display("FAIL lw_latency got %0d exp 2", lat); end
  endtask

  task automatic test_subword_load();
    logic [31:0] addrs [6] = '{32'h13, 32'h13, 32'h12, 32'h10, 32'h10, 32'h10};
    logic [2:0]  sizes [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000, 3'b001};
    logic [31:0] exps  [6] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD,
                               32'h0000BEEF, 32'hFFFFFFEF, 32'hFFFFBEEF};
    logic [31:0] rd; logic er; int lat, acc;
    for (int i = 0; i < 6; i++) begin
      do_req(1'b0, addrs[i], sizes[i], 32'h0, rd, er, lat, acc);
      checks++;
      if (rd !== exps[i] || er !== 1'b0) begin
        failures++; $display("FAIL subload_%0d got %h err %b exp %h/0", i, rd, er, exps[i]);
      end
    end
  endtask

  task automatic test_subword_store();
    logic [31:0] rd; logic er; int lat, acc;
    do_req(1'b1, 32'h11, 3'b000, 32'h12345677, rd, er, lat, acc);
    do_req(1'b0, 32'h10, 3'b010, 32'h0, rd, er, lat, acc);
    checks++; if (rd !== 32'hDEAD77EF) begin failures++; $display("FAIL sb_merge got %h exp dead77ef", rd); end
    do_req(1'b1, 32'h16, 3'b001, 32'hAAAA5678, rd, er, lat, acc);
    do_req(1'b0, 32'h14, 3'b010, 32'h0, rd, er, lat, acc);
    checks++; if (rd !== 32'h56780000) begin failures++; $display("FAIL sh_upper got %h exp 56780000", rd); end
  endtask

  task automatic test_errors();
    logic        wes   [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [31:0] addrs [7] = '{32'h12, 32'h13, 32'h1000, 32'h10, 32'h10, 32'h1000, 32'h11};
    logic [2:0]  sizes [7] = '{3'b010, 3'b001, 3'b010, 3'b011, 3'b100, 3'b010, 3'b101};
    logic [31:0] rd; logic er; int lat, acc;
    for (int i = 0; i < 7; i++) begin
      do_req(wes[i], addrs[i], sizes[i], 32'h11111111, rd, er, lat, acc);
      checks++;
      if (er !== 1'b1 || rd !== 32'h0) begin
        failures++; $display("FAIL err_%0d got err %b rdata %h exp 1/0", i, er, rd);
      end
    end
    do_req(1'b0, 32'h10, 3'b010, 32'h0, rd, er, lat, acc);
    checks++; if (rd !== 32'hDEAD77EF) begin failures++; $display("FAIL err_nowrite10 got %h exp dead77ef", rd); end
    do_req(1'b0, 32'h0, 3'b010, 32'h0, rd, er, lat, acc);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL err_nowrap0 got %h exp 0", rd); end
    do_req(1'b1, 32'hFFC, 3'b010, 32'hCAFEF00D, rd, er, lat, acc);
    do_req(1'b0, 32'hFFC, 3'b010, 32'h0, rd, er, lat, acc);
    checks++; if (rd !== 32'hCAFEF00D || er !== 1'b0) begin failures++; $display("FAIL top_word got %h err %b exp cafef00d/0", rd, er); end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd; logic er; int lat, acc, n;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_size = 3'b010;
    @(posedge clk); #1 req_valid = 1'b0;
    n = 0;
    while (!resp_valid && n < 20) begin @(negedge clk); n++; end
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_size = 3'b010; req_wdata = 32'h0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (resp_valid !== 1'b1 || resp_rdata !== 32'hDEAD77EF || req_ready !== 1'b0) begin
        failures++;
        $display("FAIL stall_%0d got valid %b rdata %h ready %b exp 1/dead77ef/0", i, resp_valid, resp_rdata, req_ready);
      end
    end
    req_valid = 1'b0; resp_ready = 1'b1;
    @(posedge clk); #1 resp_ready = 1'b0;
    do_req(1'b0, 32'h10, 3'b010, 32'h0, rd, er, lat, acc);
    checks++; if (rd !== 32'hDEAD77EF) begin failures++; $display("FAIL stall_ignored got %h exp dead77ef", rd); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic er; int lat, a0, a1, a2;
    do_req(1'b0, 32'h10, 3'b010, 32'h0, rd, er, lat, a0);
    do_req(1'b0, 32'h14, 3'b010, 32'h0, rd, er, lat, a1);
    do_req(1'b0, 32'hFFC, 3'b010, 32'h0, rd, er, lat, a2);
    checks++; if (a1 - a0 !== 3 || a2 - a1 !== 3) begin failures++; $display("FAIL b2b_spacing got %0d,%0d exp 3,3", a1 - a0, a2 - a1); end
    checks++; if (rd !== 32'hCAFEF00D) begin failures++; $display("FAIL b2b_data got %h exp cafef00d", rd); end
  endtask

  task automatic test_reset_in_access();
    logic [31:0] rd; logic er; int lat, acc; logic seen = 1'b0;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rsta_ready got %b exp 1", req_ready); end
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_size = 3'b010; req_wdata = 32'h5A5A5A5A;
    @(posedge clk); #1 req_valid = 1'b0; reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (resp_valid) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL rsta_resp got %b exp 0", seen); end
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rsta_idle got %b exp 1", req_ready); end
    do_req(1'b0, 32'h20, 3'b010, 32'h0, rd, er, lat, acc);
    checks++; if (rd !== 32'h0 || er !== 1'b0) begin failures++; $display("FAIL rsta_nowrite got %h err %b exp 0/0", rd, er); end
  endtask

  initial begin
    test_reset();
    test_word();
    test_subword_load();
    test_subword_store();
    test_errors();
    test_backpressure();
    test_back_to_back();
    test_reset_in_access();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter: MEM_WORDS, 1024, number of 32-bit words of storage (byte range 0 .. 4*MEM_WORDS-1).
REQ-002 SHALL have one clock; reset is synchronous and active-high.
REQ-003 SHALL have port: clk  input  1  rising-edge clock.
REQ-004 SHALL have port: reset  input  1  synchronous active-high reset.
REQ-005 SHALL have port: req_valid  input  1  CPU load/store request present.
REQ-006 SHALL have port: req_ready  output  1  responder can accept a request.
REQ-007 SHALL have port: req_we  input  1  1 = store, 0 = load.
REQ-008 SHALL have port: req_addr  input  32  byte address.
REQ-009 SHALL have port: req_size  input  3  RISC-V funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-010 SHALL have port: req_wdata  input  32  store data, right-aligned.
REQ-011 SHALL have port: resp_valid  output  1  response present.
REQ-012 SHALL have port: resp_ready  input  1  CPU accepts response.
REQ-013 SHALL have port: resp_rdata  output  32  load data, extended; 0 for stores and errors.
REQ-014 SHALL have port: resp_err  output  1  request rejected (misaligned, out of range, illegal size).

Function
REQ-015 SHALL implement FSM states IDLE, ACCESS, RESPOND; exactly one request outstanding.
REQ-016 SHALL drive req_ready = 1 only in IDLE; request accepted on the cycle req_valid & req_ready.
REQ-017 SHALL latch we/addr/size/wdata on acceptance; IDLE -> ACCESS.
REQ-018 SHALL in ACCESS perform the memory read or write, compute rdata/err, and go ACCESS -> RESPOND unconditionally.
REQ-019 SHALL assert resp_valid in RESPOND only, holding rdata/err stable until resp_ready; RESPOND -> IDLE on resp_valid & resp_ready.
REQ-020 SHALL give latency: resp_valid first high 2 cycles after acceptance; best-case throughput one request per 3 cycles.
REQ-021 SHALL use little-endian lanes: byte lane = addr[1:0], halfword lane = addr[1].
REQ-022 SHALL on loads sign-extend B/H, zero-extend BU/HU, and return W unmodified.
REQ-023 SHALL on stores write only the addressed byte(s) from req_wdata[7:0] / [15:0] / [31:0]; other bytes unchanged.
REQ-024 SHALL flag err for: H/HU with addr[0]=1; W with addr[1:0]!=0; addr >= 4*MEM_WORDS; size 011/110/111; store with size 100/101.
REQ-025 SHALL on err perform no memory write and return resp_rdata = 0, resp_err = 1.
REQ-026 SHALL ignore req_valid outside IDLE (no queuing, no state change).
REQ-027 SHALL make a load after a store to the same address return the stored data (no stale read).
REQ-028 SHALL zero-initialise memory at time 0; reset SHALL NOT clear memory contents.

Reset
REQ-029 SHALL on reset force state IDLE, resp_valid 0, resp_rdata 0, resp_err 0; req_ready 1 on the first cycle after reset deasserts.
REQ-030 SHALL give reset priority: a store in ACCESS on a reset cycle is not written; any pending response is discarded.

Verification
REQ-031 SHALL pass: SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> resp_rdata 0xDEADBEEF, err 0, resp_valid 2 cycles after acceptance.
REQ-032 SHALL pass: after REQ-031, LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x12 -> 0xFFFFDEAD; LHU 0x10 -> 0x0000BEEF.
REQ-033 SHALL pass: SB 0x11 data 0x12345677 over 0xDEADBEEF, then LW 0x10 -> 0xDEAD77EF.
REQ-034 SHALL pass: LW 0x12, SH 0x13, LW 0x1000 (MEM_WORDS=1024), size 011 -> each err 1, rdata 0, memory unchanged.
REQ-035 SHALL pass: resp_ready held 0 for 5 cycles -> resp_valid/rdata stable and req_ready 0 throughout; new req_valid during that time ignored.
REQ-036 SHALL pass: SW 0x20 accepted, reset asserted in ACCESS cycle -> resp_valid never asserted, later LW 0x20 -> 0x00000000.
